iter_divider: RTL and testbench

ITER_DIVIDER -- requirements
Module: iter_divider

---
 rtl/iter_divider_if.sv | 26 ++
 rtl/iter_divider.sv | 187 ++++++++++++++++++
 tb/tb_iter_divider.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_divider_if.sv
// Request/response bundle for the iterative divider: operands and start in,
// status flags and results out.
interface iter_divider_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        sign;
  logic        busy;
  logic        done;
  logic [15:0] Quo;
  logic [15:0] Rem;
  logic        dbz;
  logic        Ofl;
  logic        Z;
  logic        N;

  modport master (
    output start, A, B, sign,
    input  busy, done, Quo, Rem, dbz, Ofl, Z, N
  );

  modport slave (
    input  start, A, B, sign,
    output busy, done, Quo, Rem, dbz, Ofl, Z, N
  );
endinterface

// File: rtl/iter_divider.sv
// 16-bit restoring divider, one quotient bit per cycle, signed or unsigned.
// Results and flags are registered at DONE and held until the next DONE.
module iter_divider (
  input logic           clk,
  input logic           rst_n,
  iter_divider_if.slave div
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] b_q, b_d;
  logic [15:0] dq_q, dq_d;       // dividend shifting out, quotient shifting in
  logic [16:0] rem_q, rem_d;
  logic        neg_q, neg_d;
  logic        a_neg_q, a_neg_d;
  logic        dbz_q, dbz_d;
  logic        ofl_q, ofl_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] quo_out_q, quo_out_d;
  logic [15:0] rem_out_q, rem_out_d;
  logic        dbz_out_q, dbz_out_d;
  logic        ofl_out_q, ofl_out_d;
  logic        z_q, z_d;
  logic        n_q, n_d;

  logic [16:0] trial;
  logic [16:0] diff;
  logic [15:0] a_mag;
  logic [15:0] b_mag;
  logic [15:0] rem_neg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (div.start) begin
          state_d = (div.B == 16'd0) ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == 4'd15) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    b_d       = b_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    neg_d     = neg_q;
    a_neg_d   = a_neg_q;
    dbz_d     = dbz_q;
    ofl_d     = ofl_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_out_d = dbz_out_q;
    ofl_out_d = ofl_out_q;
    z_d       = z_q;
    n_d       = n_q;

    trial   = {rem_q[15:0], dq_q[15]};
    diff    = trial - {1'b0, b_q};
    a_mag   = (div.sign && div.A[15]) ? 16'(-div.A) : div.A;
    b_mag   = (div.sign && div.B[15]) ? 16'(-div.B) : div.B;
    rem_neg = 16'(-rem_q[15:0]);

    unique case (state_q)
      StIdle: begin
        if (div.start) begin
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          b_d     = b_mag;
          neg_d   = div.sign & (div.A[15] ^ div.B[15]);
          a_neg_d = div.sign & div.A[15];
          ofl_d   = div.sign & (div.A == 16'h8000) & (div.B == 16'hFFFF);
          if (div.B == 16'd0) begin
            // Divide-by-zero result is preloaded; CALC and FIX are skipped.
            dq_d  = 16'hFFFF;
            rem_d = {1'b0, div.A};
            dbz_d = 1'b1;
          end else begin
            dq_d  = a_mag;
            rem_d = 17'd0;
            dbz_d = 1'b0;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 4'd1;
        if (!diff[16]) begin
          rem_d = diff;
          dq_d  = {dq_q[14:0], 1'b1};
        end else begin
          rem_d = trial;
          dq_d  = {dq_q[14:0], 1'b0};
        end
      end
      StFix: begin
        if (neg_q) begin
          dq_d = 16'(-dq_q);
        end
        if (a_neg_q) begin
          rem_d = {1'b0, rem_neg};
        end
      end
      StDone: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        quo_out_d = dq_q;
        rem_out_d = rem_q[15:0];
        dbz_out_d = dbz_q;
        ofl_out_d = ofl_q;
        z_d       = (dq_q == 16'd0);
        n_d       = dq_q[15];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= 4'd0;
      b_q       <= 16'd0;
      dq_q      <= 16'd0;
      rem_q     <= 17'd0;
      neg_q     <= 1'b0;
      a_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      ofl_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_out_q <= 16'd0;
      rem_out_q <= 16'd0;
      dbz_out_q <= 1'b0;
      ofl_out_q <= 1'b0;
      z_q       <= 1'b1;
      n_q       <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      b_q       <= b_d;
      dq_q      <= dq_d;
      rem_q     <= rem_d;
      neg_q     <= neg_d;
      a_neg_q   <= a_neg_d;
      dbz_q     <= dbz_d;
      ofl_q     <= ofl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_out_q <= dbz_out_d;
      ofl_out_q <= ofl_out_d;
      z_q       <= z_d;
      n_q       <= n_d;
    end
  end

  assign div.busy = busy_q;
  assign div.done = done_q;
  assign div.Quo  = quo_out_q;
  assign div.Rem  = rem_out_q;
  assign div.dbz  = dbz_out_q;
  assign div.Ofl  = ofl_out_q;
  assign div.Z    = z_q;
  assign div.N    = n_q;

endmodule

// File: tb/tb_iter_divider.sv
// Randomised and directed bench for iter_divider against an integer-arithmetic model.
module tb_iter_divider;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  iter_divider_if dif ();

  iter_divider dut (
    .clk  (clk),
    .rst_n(rst_n),
    .div  (dif)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz, output logic ov);
    int ia, ib, iq, ir;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 16'd0) begin
      q  = 16'hFFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      if (s) begin
        ia = int'($signed(a));
        ib = int'($signed(b));
      end else begin
        ia = int'(a);
        ib = int'(b);
      end
      if (s && ia == -32768 && ib == -1) begin
        q  = 16'h8000;
        r  = 16'd0;
        ov = 1'b1;
      end else begin
        iq = ia / ib;
        ir = ia % ib;
        q  = iq[15:0];
        r  = ir[15:0];
      end
    end
  endfunction

  // Caller is positioned 1 time unit after a clock edge with the DUT idle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input string tag);
    logic [15:0] eq, er, q0, r0;
    logic        edz, eov;
    int          lat, k, busy_cnt;
    bit          got, stable;
    model(a, b, s, eq, er, edz, eov);
    lat = (b == 16'd0) ? 1 : 18;
    dif.start = 1'b1;
    dif.A     = a;
    dif.B     = b;
    dif.sign  = s;
    @(posedge clk) #1;
    dif.start = 1'b0;
    dif.A     = 16'($urandom);
    dif.B     = 16'($urandom);
    dif.sign  = 1'($urandom);
    q0 = dif.Quo;
    r0 = dif.Rem;
    busy_cnt = 0;
    k = 0;
    got = 0;
    stable = 1;
    while (k < 40 && !got) begin
      if (dif.busy) busy_cnt++;
      @(posedge clk) #1;
      k++;
      if (dif.done) got = 1;
      else if (dif.Quo !== q0 || dif.Rem !== r0) stable = 0;
    end
    n_total++;
    if (!got || k != lat) $display("FAIL %s latency: got %0d want %0d", tag, got ? k : -1, lat);
    else n_pass++;
    n_total++;
    if (busy_cnt != lat) $display("FAIL %s busy cycles: got %0d want %0d", tag, busy_cnt, lat);
    else n_pass++;
    n_total++;
    if (!stable) $display("FAIL %s outputs changed before done", tag);
    else n_pass++;
    n_total++;
    if (dif.Quo !== eq) $display("FAIL %s Quo: got %h want %h", tag, dif.Quo, eq);
    else n_pass++;
    n_total++;
    if (dif.Rem !== er) $display("FAIL %s Rem: got %h want %h", tag, dif.Rem, er);
    else n_pass++;
    n_total++;
    if ({dif.dbz, dif.Ofl, dif.Z, dif.N} !== {edz, eov, eq == 16'd0, eq[15]})
      $display("FAIL %s flags dbz/Ofl/Z/N: got %b want %b", tag,
               {dif.dbz, dif.Ofl, dif.Z, dif.N}, {edz, eov, eq == 16'd0, eq[15]});
    else n_pass++;
    @(posedge clk) #1;
    n_total++;
    if (dif.done !== 1'b0 || dif.Quo !== eq || dif.Rem !== er)
      $display("FAIL %s pulse/hold: got done=%b Quo=%h Rem=%h want done=0 Quo=%h Rem=%h",
               tag, dif.done, dif.Quo, dif.Rem, eq, er);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    dif.start = 1'b0;
    dif.A     = 16'd0;
    dif.B     = 16'd0;
    dif.sign  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({dif.Quo, dif.Rem} !== 32'd0)
      $display("FAIL reset Quo/Rem: got %h/%h want 0/0", dif.Quo, dif.Rem);
    else n_pass++;
    n_total++;
    if ({dif.busy, dif.done, dif.dbz, dif.Ofl, dif.Z, dif.N} !== 6'b000010)
      $display("FAIL reset flags busy/done/dbz/Ofl/Z/N: got %b want 000010",
               {dif.busy, dif.done, dif.dbz, dif.Ofl, dif.Z, dif.N});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_op(16'd100, 16'd7, 1'b0, "u100_7");
    n_total++;
    if ({dif.Quo, dif.Rem} !== {16'd14, 16'd2})
      $display("FAIL u100_7 const: got %h/%h want 000e/0002", dif.Quo, dif.Rem);
    else n_pass++;
    do_op(16'hFF9C, 16'd7, 1'b1, "sm100_7");
    n_total++;
    if ({dif.Quo, dif.Rem, dif.N, dif.Ofl} !== {16'hFFF2, 16'hFFFE, 1'b1, 1'b0})
      $display("FAIL sm100_7 const: got %h/%h N=%b Ofl=%b want fff2/fffe N=1 Ofl=0",
               dif.Quo, dif.Rem, dif.N, dif.Ofl);
    else n_pass++;
    do_op(16'hFFFF, 16'd1, 1'b0, "uffff_1");
    n_total++;
    if ({dif.Quo, dif.Rem} !== {16'hFFFF, 16'd0})
      $display("FAIL uffff_1 const: got %h/%h want ffff/0000", dif.Quo, dif.Rem);
    else n_pass++;
    do_op(16'hFFFF, 16'd1, 1'b1, "sm1_1");
    n_total++;
    if ({dif.Quo, dif.Rem} !== {16'hFFFF, 16'd0})
      $display("FAIL sm1_1 const: got %h/%h want ffff/0000", dif.Quo, dif.Rem);
    else n_pass++;
    do_op(16'd1234, 16'd0, 1'b0, "dbz");
    n_total++;
    if ({dif.Quo, dif.Rem, dif.dbz, dif.Ofl} !== {16'hFFFF, 16'd1234, 1'b1, 1'b0})
      $display("FAIL dbz const: got %h/%h dbz=%b Ofl=%b want ffff/04d2 dbz=1 Ofl=0",
               dif.Quo, dif.Rem, dif.dbz, dif.Ofl);
    else n_pass++;
    do_op(16'h8000, 16'hFFFF, 1'b1, "ovf");
    n_total++;
    if ({dif.Quo, dif.Rem, dif.Ofl} !== {16'h8000, 16'd0, 1'b1})
      $display("FAIL ovf const: got %h/%h Ofl=%b want 8000/0000 Ofl=1",
               dif.Quo, dif.Rem, dif.Ofl);
    else n_pass++;
    do_op(16'd5, 16'd9, 1'b0, "u5_9");
    n_total++;
    if ({dif.Quo, dif.Rem, dif.Z, dif.Ofl} !== {16'd0, 16'd5, 1'b1, 1'b0})
      $display("FAIL u5_9 const: got %h/%h Z=%b Ofl=%b want 0000/0005 Z=1 Ofl=0",
               dif.Quo, dif.Rem, dif.Z, dif.Ofl);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic        s;
    int          sel;
    for (int i = 0; i < 40; i++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      s   = 1'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0) b = 16'd0;
      else if (sel == 1) begin
        a = 16'h8000;
        b = 16'hFFFF;
        s = 1'b1;
      end else if (sel == 2) b = 16'($urandom_range(1, 15));
      else if (sel == 3) b = 16'hFFFF - 16'($urandom_range(0, 3));
      do_op(a, b, s, $sformatf("rnd%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q1, r1, q2, r2;
    logic        dz, ov;
    int          k;
    model(16'd60000, 16'd123, 1'b0, q1, r1, dz, ov);
    model(16'hF000, 16'd3, 1'b1, q2, r2, dz, ov);
    dif.start = 1'b1;
    dif.A     = 16'd60000;
    dif.B     = 16'd123;
    dif.sign  = 1'b0;
    @(posedge clk) #1;
    k = 0;
    while (k < 40 && !dif.done) begin
      @(posedge clk) #1;
      k++;
    end
    n_total++;
    if (k != 18 || {dif.Quo, dif.Rem} !== {q1, r1})
      $display("FAIL b2b first: got k=%0d %h/%h want k=18 %h/%h", k, dif.Quo, dif.Rem, q1, r1);
    else n_pass++;
    dif.A    = 16'hF000;
    dif.B    = 16'd3;
    dif.sign = 1'b1;
    @(posedge clk) #1;
    dif.start = 1'b0;
    n_total++;
    if (dif.busy !== 1'b1) $display("FAIL b2b restart busy: got %b want 1", dif.busy);
    else n_pass++;
    k = 0;
    while (k < 40 && !dif.done) begin
      @(posedge clk) #1;
      k++;
    end
    n_total++;
    if (k != 18 || {dif.Quo, dif.Rem} !== {q2, r2})
      $display("FAIL b2b second: got k=%0d %h/%h want k=18 %h/%h", k, dif.Quo, dif.Rem, q2, r2);
    else n_pass++;
    @(posedge clk) #1;
  endtask

  task automatic test_reset_abort();
    int k, first, dones;
    dif.start = 1'b1;
    dif.A     = 16'd1000;
    dif.B     = 16'd3;
    dif.sign  = 1'b0;
    @(posedge clk) #1;
    dif.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk) #1;
    n_total++;
    if ({dif.Quo, dif.Rem} !== 32'd0)
      $display("FAIL abort Quo/Rem: got %h/%h want 0/0", dif.Quo, dif.Rem);
    else n_pass++;
    n_total++;
    if ({dif.busy, dif.done, dif.dbz, dif.Ofl, dif.Z, dif.N} !== 6'b000010)
      $display("FAIL abort flags busy/done/dbz/Ofl/Z/N: got %b want 000010",
               {dif.busy, dif.done, dif.dbz, dif.Ofl, dif.Z, dif.N});
    else n_pass++;
    rst_n     = 1'b1;
    dif.start = 1'b1;
    dif.A     = 16'd50;
    dif.B     = 16'd5;
    @(posedge clk) #1;
    dif.start = 1'b0;
    n_total++;
    if (dif.busy !== 1'b1) $display("FAIL post-reset accept busy: got %b want 1", dif.busy);
    else n_pass++;
    first = -1;
    dones = 0;
    for (k = 1; k <= 45; k++) begin
      if (k == 6) begin
        dif.start = 1'b1;
        dif.A     = 16'd7;
        dif.B     = 16'd7;
      end else if (k == 7) dif.start = 1'b0;
      @(posedge clk) #1;
      if (dif.done) begin
        dones++;
        if (first < 0) first = k;
      end
    end
    n_total++;
    if (first != 18 || dones != 1)
      $display("FAIL post-reset done: got first=%0d count=%0d want first=18 count=1",
               first, dones);
    else n_pass++;
    n_total++;
    if ({dif.Quo, dif.Rem} !== {16'd10, 16'd0})
      $display("FAIL post-reset result: got %h/%h want 000a/0000", dif.Quo, dif.Rem);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
